// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - state encoding shared by the bit-serial adder
package serial_adder_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - single combinational full-adder cell
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder, one bit pair per clock, LSB first
// Optional SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a - b.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic [WIDTH-2:0]   r_sum_sh;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;
   logic               r_carry;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_s;
   logic               w_c;
   logic               w_last;
   logic [WIDTH-1:0]   w_sum_next;
   logic [WIDTH-1:0]   w_b_load;
   logic               w_carry_load;

   // Subtraction is a + ~b + 1, so only the load values differ.
`ifdef SERIAL_ADDER_SUB_EN
   assign w_b_load     = sub ? ~b : b;
   assign w_carry_load = sub ? 1'b1 : cin;
`else
   assign w_b_load     = b;
   assign w_carry_load = cin;
`endif

   full_adder_cell u_fa (
      .a    (r_a_sh[0]),
      .b    (r_b_sh[0]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_c)
   );

   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_sum_next = {w_s, r_sum_sh};
   assign sum        = r_sum;
   assign cout       = r_cout;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_sum_sh <= '0;
         r_sum    <= '0;
         r_cout   <= 1'b0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a_sh  <= a;
                  r_b_sh  <= w_b_load;
                  r_carry <= w_carry_load;
                  r_cnt   <= '0;
               end
            end
            SHIFT: begin
               r_carry  <= w_c;
               r_a_sh   <= r_a_sh >> 1;
               r_b_sh   <= r_b_sh >> 1;
               r_sum_sh <= w_sum_next[WIDTH-1:1];
               r_cnt    <= r_cnt + CNT_W'(1);
               // The last bit goes straight into the result, which then holds until the next DONE.
               if (w_last) begin
                  r_sum  <= w_sum_next;
                  r_cout <= w_c;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_next = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (w_last) w_next = DONE;
         end
         DONE: begin
            busy   = 1'b1;
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             sub_drv = 1'b0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      int               acc;
      int               fin;
   } exp_t;

   exp_t             q[$];
   int               cyc = 0;
   int               checks = 0;
   int               errors = 0;
   int               last_acc = 0;
   logic [WIDTH-1:0] hold_sum = '0;
   logic             hold_cout = 1'b0;

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub_drv),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Monitor: busy is expected from the accept cycle of the oldest pending op up to its done.
   always @(negedge clk) begin : monitor
      logic eb;
      logic ed;
      eb = (q.size() > 0) && (cyc >= q[0].acc);
      ed = (q.size() > 0) && (cyc == q[0].fin);
      chk("busy", {31'd0, busy}, {31'd0, eb});
      chk("done", {31'd0, done}, {31'd0, ed});
      if (ed) begin
         chk("sum", 32'(sum), 32'(q[0].sum));
         chk("cout", {31'd0, cout}, {31'd0, q[0].cout});
         hold_sum  = q[0].sum;
         hold_cout = q[0].cout;
         void'(q.pop_front());
      end else begin
         chk("sum_hold", 32'(sum), 32'(hold_sum));
         chk("cout_hold", {31'd0, cout}, {31'd0, hold_cout});
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0) begin
         step();
         n++;
         if (n > 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, n);
            return;
         end
      end
   endtask

   task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic ic, input logic isub, input bit hold);
      logic [WIDTH:0] t;
      exp_t           e;
      wait_idle();
      a       = ia;
      b       = ib;
      cin     = ic;
      sub_drv = isub;
      start   = 1'b1;
      if (sub_drv)
         t = {1'b0, ia} - {1'b0, ib} + (WIDTH+1)'(1 << WIDTH);
      else
         t = {1'b0, ia} + {1'b0, ib} + {{WIDTH{1'b0}}, ic};
      e.sum    = t[WIDTH-1:0];
      e.cout   = t[WIDTH];
      e.acc    = cyc + 1;
      e.fin    = cyc + 1 + WIDTH;
      last_acc = cyc + 1;
      q.push_back(e);
      step();
      if (!hold) start = 1'b0;
      a   = WIDTH'($urandom);
      b   = WIDTH'($urandom);
      cin = 1'($urandom);
   endtask

   initial begin
      int a1;
      int n;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      issue(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
      issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      issue(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);

      // A start pulse in the middle of SHIFT must not start or queue anything.
      issue(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
      step();
      start = 1'b1;
      a     = 8'hFF;
      step();
      start = 1'b0;

      // Reset in SHIFT cycle 4 discards the op and clears the outputs.
      issue(8'hA7, 8'h6B, 1'b1, 1'b0, 1'b0);
      repeat (3) step();
      rst_n = 1'b0;
      q.delete();
      hold_sum  = '0;
      hold_cout = 1'b0;
      step();
      rst_n = 1'b1;
      issue(8'h21, 8'h43, 1'b1, 1'b0, 1'b0);

      issue(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
      a1 = last_acc;
      issue(8'h80, 8'h80, 1'b0, 1'b0, 1'b1);
      chk("throughput", 32'(last_acc - a1), 32'(WIDTH + 2));
      start = 1'b0;

      for (int i = 0; i < 30; i++) begin
         issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, 1'($urandom_range(0, 1)));
         start = 1'b0;
         repeat ($urandom_range(0, 3)) step();
      end

`ifdef SERIAL_ADDER_SUB_EN
      issue(8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
      issue(8'h00, 8'h01, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++)
         issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      sub_drv = 1'b0;
`endif

      n = 0;
      while (q.size() > 0 && n < 200) begin
         step();
         n++;
      end
      chk("queue_empty", 32'(q.size()), 32'd0);
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
